// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encodings, opcodes, datapath selects and control word for multicycle_controller
// Optional feature macro: MC_JAL_EN (jal decode and JAL state).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       halt;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic op_known(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || ((op == OP_JAL) && JAL_EN);
  endfunction

endpackage

// File: rtl/mc_state_decode.sv
// rtl/mc_state_decode.sv - combinational state-to-control-word map
// Optional feature macro: MC_JAL_EN (JAL state outputs).
module mc_state_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      S_JAL: begin
        if (JAL_EN) begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.pc_update = 1'b1;
        end
      end
      S_HALT: ctrl.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM (state register, next-state, output qualification)
// Optional feature macro: MC_JAL_EN (jal decode and JAL state, via mc_pkg::JAL_EN).
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int ILL_HALT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  logic       fetch_gate;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LOAD) || (op == OP_STORE)) state_d = S_MEMADR;
        else if (op == OP_RTYPE)                 state_d = S_EXECUTER;
        else if (op == OP_ITYPE)                 state_d = S_EXECUTEI;
        else if (op == OP_BEQ)                   state_d = S_BEQ;
        else if ((op == OP_JAL) && JAL_EN)       state_d = S_JAL;
        else state_d = (ILL_HALT != 0) ? S_HALT : S_FETCH;
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = JAL_EN ? S_ALUWB : S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_state_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Strobes are masked during the reset cycle so a mid-instruction reset never writes.
  always_comb begin
    fetch_gate = (state_q != S_FETCH) || mem_ready;
    PCWrite    = ~reset & ((ctrl.pc_update & fetch_gate) | (ctrl.branch & Zero));
    IRWrite    = ~reset & ctrl.ir_write & fetch_gate;
    MemWrite   = ~reset & ctrl.mem_write;
    RegWrite   = ~reset & ctrl.reg_write;
    AdrSrc     = ctrl.adr_src;
    ResultSrc  = ctrl.result_src;
    ALUSrcA    = ctrl.alu_src_a;
    ALUSrcB    = ctrl.alu_src_b;
    ALUOp      = ctrl.alu_op;
    illegal    = ctrl.halt | ((state_q == S_DECODE) && !op_known(op));
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller (ILL_HALT=1 and ILL_HALT=0 instances)
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  logic       PCWrite_f, AdrSrc_f, MemWrite_f, IRWrite_f, RegWrite_f, illegal_f;
  logic [1:0] ResultSrc_f, ALUSrcA_f, ALUSrcB_f, ALUOp_f;
  logic [3:0] state_f;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] lw_seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] sw_seq [3] = '{4'd0, 4'd1, 4'd2};

  always #5 clk = ~clk;

  multicycle_controller #(.ILL_HALT(1)) dut_halt (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  multicycle_controller #(.ILL_HALT(0)) dut_fetch (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite_f), .AdrSrc(AdrSrc_f), .MemWrite(MemWrite_f), .IRWrite(IRWrite_f),
    .RegWrite(RegWrite_f), .ResultSrc(ResultSrc_f), .ALUSrcA(ALUSrcA_f), .ALUSrcB(ALUSrcB_f),
    .ALUOp(ALUOp_f), .illegal(illegal_f), .state(state_f)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; op = 7'd0; Zero = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0; #1;
    chk("rst_state", state, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_illegal", illegal, 0);
    cyc();
    chk("fetch_hold", state, 0);

    // lw with mem_ready high: 0,1,2,3,4 then back to FETCH
    op = 7'b0000011; mem_ready = 1'b1; #1;
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_pcwrite", PCWrite, 1);
    chk("fetch_adrsrc", AdrSrc, 0);
    chk("fetch_srca", ALUSrcA, 0);
    chk("fetch_srcb", ALUSrcB, 2);
    chk("fetch_aluop", ALUOp, 0);
    chk("fetch_resultsrc", ResultSrc, 2);
    for (int i = 0; i < 5; i++) begin
      chk("lw_state", state, lw_seq[i]);
      chk("lw_regwrite", RegWrite, (i == 4) ? 1 : 0);
      if (i == 4) chk("lw_resultsrc", ResultSrc, 1);
      if (i == 1) chk("decode_srca", ALUSrcA, 1);
      if (i == 2) chk("memadr_srca", ALUSrcA, 2);
      cyc();
    end
    chk("lw_done", state, 0);

    // sw with memory stalled three cycles in MEMWRITE
    op = 7'b0100011; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_state", state, sw_seq[i]);
      cyc();
    end
    chk("sw_memwrite_state", state, 5);
    mem_ready = 1'b0; #1;
    chk("sw_adrsrc", AdrSrc, 1);
    for (int i = 0; i < 3; i++) begin
      chk("sw_memwrite", MemWrite, 1);
      chk("sw_hold", state, 5);
      cyc();
    end
    mem_ready = 1'b1; #1;
    chk("sw_memwrite_last", MemWrite, 1);
    cyc();
    chk("sw_done", state, 0);
    chk("sw_memwrite_off", MemWrite, 0);

    // reset while stalled in MEMREAD with mem_ready pending
    op = 7'b0000011; #1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0; #1;
    chk("mr_state", state, 3);
    chk("mr_adrsrc", AdrSrc, 1);
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("mr_rstcyc_regwrite", RegWrite, 0);
    chk("mr_rstcyc_memwrite", MemWrite, 0);
    cyc();
    reset = 1'b0; mem_ready = 1'b0; #1;
    chk("mr_rst_state", state, 0);
    chk("mr_rst_regwrite", RegWrite, 0);
    chk("mr_rst_memwrite", MemWrite, 0);
    chk("mr_rst_irwrite", IRWrite, 0);

    // beq: PCWrite follows Zero in BEQ
    op = 7'b1100011; mem_ready = 1'b1; #1;
    cyc(); cyc();
    chk("beq_state", state, 9);
    Zero = 1'b1; #1;
    chk("beq_taken_pcwrite", PCWrite, 1);
    chk("beq_aluop", ALUOp, 1);
    chk("beq_srca", ALUSrcA, 2);
    Zero = 1'b0; #1;
    chk("beq_nottaken_pcwrite", PCWrite, 0);
    cyc();
    chk("beq_done", state, 0);

    // R-type
    op = 7'b0110011; #1;
    cyc(); cyc();
    chk("r_state", state, 6);
    chk("r_aluop", ALUOp, 2);
    chk("r_srca", ALUSrcA, 2);
    chk("r_srcb", ALUSrcB, 0);
    cyc();
    chk("r_wb_state", state, 8);
    chk("r_wb_regwrite", RegWrite, 1);
    chk("r_wb_resultsrc", ResultSrc, 0);
    cyc();
    chk("r_done", state, 0);

    // I-type
    op = 7'b0010011; #1;
    cyc(); cyc();
    chk("i_state", state, 7);
    chk("i_srcb", ALUSrcB, 1);
    chk("i_aluop", ALUOp, 2);
    cyc(); cyc();
    chk("i_done", state, 0);

    // jal: supported only with MC_JAL_EN
    op = 7'b1101111; #1;
    cyc();
    chk("jal_decode_state", state, 1);
`ifdef MC_JAL_EN
    chk("jal_illegal", illegal, 0);
    cyc();
    chk("jal_state", state, 10);
    chk("jal_pcwrite", PCWrite, 1);
    chk("jal_srca", ALUSrcA, 1);
    chk("jal_srcb", ALUSrcB, 2);
    cyc();
    chk("jal_wb_state", state, 8);
    chk("jal_wb_regwrite", RegWrite, 1);
    cyc();
    chk("jal_done", state, 0);
`else
    chk("jal_illegal", illegal, 1);
    chk("jal_illegal_f", illegal_f, 1);
    cyc();
    chk("jal_halt_state", state, 11);
    chk("jal_fetch_state_f", state_f, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk("jal_rst_state", state, 0);
`endif

    // unknown opcode: HALT instance absorbs, FETCH instance recovers
    op = 7'b1111111; mem_ready = 1'b1; #1;
    cyc();
    chk("ill_decode_illegal", illegal, 1);
    chk("ill_decode_illegal_f", illegal_f, 1);
    chk("ill_decode_regwrite", RegWrite, 0);
    cyc();
    chk("ill_fetch_state_f", state_f, 0);
    Zero = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", state, 11);
      chk("halt_illegal", illegal, 1);
      chk("halt_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
      cyc();
    end
    Zero = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk("halt_rst_state", state, 0);
    chk("halt_rst_illegal", illegal, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: ILL_HALT, default 1, meaning unknown opcode -> HALT state (1) or -> FETCH (0).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 PCWrite  output  1  PC enable; equals PCUpdate OR (Branch AND Zero).
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 MemWrite, IRWrite, RegWrite  output  1 each  write strobes.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath selects; ALUOp feeds the ALU decoder (00 add, 01 sub, 10 funct-decoded).
REQ-011 illegal  output  1  opcode not recognised in DECODE.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 The block SHALL be a Moore FSM: outputs depend on the state register only, except the mem_ready qualification in REQ-016 and PCWrite in REQ-007.
REQ-014 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11. Encodings 12-15 SHALL go to FETCH.
REQ-015 Transitions:
- FETCH -> DECODE on mem_ready, else hold.
- DECODE -> MEMADR for op 0000011/0100011; EXECUTER for 0110011; EXECUTEI for 0010011; BEQ for 1100011; JAL for 1101111.
- MEMADR -> MEMREAD (op[5]=0) or MEMWRITE (op[5]=1).
- MEMREAD -> MEMWB on mem_ready, else hold.
- MEMWRITE -> FETCH on mem_ready, else hold.
- EXECUTER/EXECUTEI -> ALUWB; JAL -> ALUWB; MEMWB/ALUWB/BEQ -> FETCH.
REQ-016 In FETCH, IRWrite and PCUpdate SHALL be asserted only in the cycle mem_ready=1; AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
REQ-017 Per-state outputs (unlisted signals 0):
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle in the state.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-018 Unknown opcode in DECODE: illegal=1 in that cycle; next state HALT if ILL_HALT=1, else FETCH.
REQ-019 HALT SHALL be absorbing (all strobes 0, illegal=1) until reset.
REQ-020 Instruction latency (mem_ready always 1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-021 A clock edge with reset=1 SHALL force state=FETCH, overriding any transition, including mid-instruction or a pending mem_ready.
REQ-022 In the reset cycle and the cycle after it, all write strobes SHALL be 0 until FETCH outputs apply.

Configuration
REQ-023 Macro MC_JAL_EN:
- Defined: the JAL state and jal decode exist.
- Undefined: opcode 1101111 SHALL be treated as unknown (REQ-018), and encoding 10 SHALL go to FETCH.

Structure
REQ-024 Package mc_pkg SHALL hold the state enum, the opcode constants, the ALUOp/ResultSrc/ALUSrc select constants and a packed control-word typedef.
REQ-025 Sub-module mc_state_decode SHALL map state to the control word combinationally; the top holds the state register and next-state logic.

Verification
REQ-026 reset=1 mid-MEMREAD -> next cycle state=0, RegWrite=0, MemWrite=0.
REQ-027 lw, mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 only in state 4; ResultSrc=01.
REQ-028 sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then state=0.
REQ-029 beq with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0.
REQ-030 op=1111111, ILL_HALT=1 -> illegal=1, state stays 11 for 10 cycles; with ILL_HALT=0 -> returns to 0.
REQ-031 jal with MC_JAL_EN defined -> states 0,1,10,8; with it undefined -> same stimulus behaves as REQ-030.
